// File: rtl/mw93_pkg.sv
// rtl/mw93_pkg.sv - shared FSM states, opcodes and command-header helper for the Microwire read master
package mw93_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DUMMY,
    DATA,
    DONE,
    GAP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_ERASE = 2'b11
  } op_e;

  localparam logic START_BIT = 1'b1;

  function automatic logic [2:0] cmd_hdr(input op_e op);
    return {START_BIT, op};
  endfunction

endpackage

// File: rtl/mw93_sk_gen.sv
// rtl/mw93_sk_gen.sv - SK divider: level plus single-cycle rise/fall strobes, running only while enabled
module mw93_sk_gen #(
  parameter int SK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sk,
  output logic o_sk_rise,
  output logic o_sk_fall
);

  localparam int CNT_W = (SK_DIV > 1) ? $clog2(SK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sk;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == CNT_W'(SK_DIV - 1));

  // Dropping the enable parks SK low and restarts the half-period count.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_cnt <= '0;
      r_sk  <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sk  <= ~r_sk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sk      = r_sk;
  assign o_sk_rise = w_tick && !r_sk;
  assign o_sk_fall = w_tick && r_sk;

endmodule

// File: rtl/mw93_read_ctrl.sv
// rtl/mw93_read_ctrl.sv - Microwire 93xx READ master; MW93_DUMMY_CHECK_EN adds err for a nonzero dummy bit
module mw93_read_ctrl
  import mw93_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int SK_DIV  = 4,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mw_cs,
  output logic              mw_sk,
  output logic              mw_di,
`ifdef MW93_DUMMY_CHECK_EN
  output logic              err,
`endif
  input  logic              mw_do
);

  localparam int CMD_W   = 3 + ADDR_W;
  localparam int BIT_W   = $clog2(3 + ADDR_W + DATA_W + 1);
  localparam int GAP_CLK = CS_IDLE * 2 * SK_DIV;
  localparam int GAP_W   = $clog2(GAP_CLK + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_sr;
  logic [CMD_W-1:0]  r_cmd;
  logic [BIT_W-1:0]  r_bit;
  logic [GAP_W-1:0]  r_gap;
  logic              r_cs;
  logic              w_sk;
  logic              w_sk_rise;
  logic              w_sk_fall;
`ifdef MW93_DUMMY_CHECK_EN
  logic              r_dummy;
  logic              r_err;
`endif

  mw93_sk_gen #(
    .SK_DIV(SK_DIV)
  ) u_sk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_cs),
    .o_sk     (w_sk),
    .o_sk_rise(w_sk_rise),
    .o_sk_fall(w_sk_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req && r_ready) w_state_nxt = CMD;
      CMD:     if (w_sk_fall && r_bit == BIT_W'(CMD_W - 1)) w_state_nxt = DUMMY;
      DUMMY:   if (w_sk_rise) w_state_nxt = DATA;
      DATA:    if (w_sk_fall && r_bit == BIT_W'(DATA_W)) w_state_nxt = DONE;
      DONE:    w_state_nxt = GAP;
      GAP:     if (r_gap == GAP_W'(GAP_CLK - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The command word shifts out MSB first and empties to zero, so DI idles low afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_sr     <= '0;
      r_cmd    <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
      r_cs     <= 1'b0;
`ifdef MW93_DUMMY_CHECK_EN
      r_dummy  <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req && r_ready) begin
            r_ready <= 1'b0;
            r_cs    <= 1'b1;
            r_cmd   <= {cmd_hdr(OP_READ), addr};
            r_bit   <= '0;
          end
        end
        CMD: begin
          if (w_sk_fall) begin
            r_cmd <= r_cmd << 1;
            r_bit <= (r_bit == BIT_W'(CMD_W - 1)) ? '0 : r_bit + 1'b1;
          end
        end
`ifdef MW93_DUMMY_CHECK_EN
        DUMMY: begin
          if (w_sk_rise) r_dummy <= mw_do;
        end
`endif
        DATA: begin
          if (w_sk_rise && r_bit != BIT_W'(DATA_W)) begin
            r_sr  <= {r_sr[DATA_W-2:0], mw_do};
            r_bit <= r_bit + 1'b1;
          end
        end
        DONE: begin
          r_cs     <= 1'b0;
          r_rdata  <= r_sr;
          r_rvalid <= 1'b1;
          r_gap    <= '0;
`ifdef MW93_DUMMY_CHECK_EN
          r_err    <= r_dummy;
`endif
        end
        GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GAP_W'(GAP_CLK - 1)) r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready  = r_ready;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign mw_cs  = r_cs;
  assign mw_sk  = w_sk;
  assign mw_di  = r_cmd[CMD_W-1];
`ifdef MW93_DUMMY_CHECK_EN
  assign err    = r_err;
`endif

endmodule

// File: tb/tb_mw93_read_ctrl.sv
// tb/tb_mw93_read_ctrl.sv - directed scoreboard bench for mw93_read_ctrl with a 93C46-style device model
module tb_mw93_read_ctrl;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int SK_DIV  = 4;
  localparam int CS_IDLE = 2;
  localparam int CMD_W   = 3 + ADDR_W;
  localparam int RISES   = CMD_W + 1 + DATA_W;
  localparam int LAT     = RISES * 2 * SK_DIV + 1;
  localparam int GAP_CLK = CS_IDLE * 2 * SK_DIV;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              req   = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mw_cs;
  logic              mw_sk;
  logic              mw_di;
  logic              mw_do = 1'b0;
`ifdef MW93_DUMMY_CHECK_EN
  logic              err;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CMD_W-1:0]  cmd;
    logic              err;
  } exp_t;

  exp_t              q[$];
  exp_t              tmp;
  logic [DATA_W-1:0] mem [64];
  logic              dummy_val = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                c0 = 0;
  int                n_rv;
  int                cs_low;
  int                m_rises = 0;
  logic [CMD_W-1:0]  m_cmd = '0;
  logic              m_prev_sk = 1'b0;
  logic              m_prev_cs = 1'b0;

  mw93_read_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SK_DIV (SK_DIV),
    .CS_IDLE(CS_IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .addr  (addr),
    .ready (ready),
    .rvalid(rvalid),
    .rdata (rdata),
    .mw_cs (mw_cs),
    .mw_sk (mw_sk),
    .mw_di (mw_di),
`ifdef MW93_DUMMY_CHECK_EN
    .err   (err),
`endif
    .mw_do (mw_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: latches DI on each SK rise, then presents the bit for the next rise.
  always @(negedge clk) begin
    if (mw_cs && !m_prev_cs) begin
      m_rises = 0;
      m_cmd   = '0;
      mw_do   = 1'b0;
    end
    if (mw_cs && mw_sk && !m_prev_sk) begin
      if (m_rises < CMD_W) m_cmd = {m_cmd[CMD_W-2:0], mw_di};
      m_rises = m_rises + 1;
      if (m_rises == CMD_W) mw_do = dummy_val;
      else if (m_rises > CMD_W && m_rises < RISES) mw_do = mem[m_cmd[ADDR_W-1:0]][RISES-1-m_rises];
      else mw_do = 1'b0;
    end
    m_prev_sk = mw_sk;
    m_prev_cs = mw_cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < GAP_CLK + 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, ready, 1);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic dv);
    exp_t e;
    e.data = mem[a];
    e.cmd  = {3'b110, a};
    e.err  = dv;
    q.push_back(e);
  endtask

  task automatic issue(input string tag, input logic [ADDR_W-1:0] a, input logic dv);
    wait_ready(tag);
    @(negedge clk);
    req = 1'b1;
    addr = a;
    dummy_val = dv;
    @(posedge clk);
    #1;
    c0 = cyc;
    chk({tag, "_accept"}, ready, 0);
    push_exp(a, dv);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int   n = 0;
    exp_t e;
    while (rvalid !== 1'b1 && n < LAT + 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid_seen"}, rvalid, 1);
    if (rvalid === 1'b1) begin
      if (q.size() != 0) e = q.pop_front();
      else e = '0;
      chk({tag, "_rdata"}, rdata, e.data);
      chk({tag, "_latency"}, cyc - c0, LAT);
      chk({tag, "_di_bits"}, m_cmd, e.cmd);
      chk({tag, "_sk_rises"}, m_rises, RISES);
      chk({tag, "_cs_low_at_rvalid"}, mw_cs, 0);
`ifdef MW93_DUMMY_CHECK_EN
      chk({tag, "_err"}, err, e.err);
`endif
      @(negedge clk);
      chk({tag, "_rvalid_one_cycle"}, rvalid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'(i * 257) ^ 16'h5A3C;
    mem[6'h2A] = 16'hA55A;
    mem[6'h00] = 16'h0001;
    mem[6'h3F] = 16'hFFFF;
    mem[6'h05] = 16'h1234;
    mem[6'h11] = 16'hDEAD;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_cs", mw_cs, 0);
    chk("rst_sk", mw_sk, 0);
    chk("rst_di", mw_di, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    rst_n = 1'b1;

    issue("single", 6'h2A, 1'b0);
    wait_rsp("single");
    chk("single_cmd_literal", m_cmd, 9'b110101010);
    chk("single_rdata_literal", rdata, 16'hA55A);

    // Back-to-back: req stays high so the second read is taken the clk ready returns.
    wait_ready("b2b");
    @(negedge clk);
    req = 1'b1;
    addr = 6'h00;
    dummy_val = 1'b0;
    @(posedge clk);
    #1;
    c0 = cyc;
    chk("b2b0_accept", ready, 0);
    push_exp(6'h00, 1'b0);
    @(negedge clk);
    addr = 6'h3F;
    wait_rsp("b2b0");
    cs_low = 1;
    while (mw_cs !== 1'b1 && cs_low < GAP_CLK + 50) begin
      cs_low++;
      @(negedge clk);
    end
    c0 = cyc;
    chk("b2b1_accept", ready, 0);
    chk("b2b_cs_gap_min", cs_low >= GAP_CLK, 1);
    push_exp(6'h3F, 1'b0);
    req = 1'b0;
    wait_rsp("b2b1");

    issue("ignored", 6'h05, 1'b0);
    while (cyc < c0 + 100) @(negedge clk);
    req = 1'b1;
    addr = 6'h11;
    @(posedge clk);
    #1;
    chk("ignored_ready_low", ready, 0);
    chk("ignored_cs_high", mw_cs, 1);
    @(negedge clk);
    req = 1'b0;
    addr = '0;
    wait_rsp("ignored");
    repeat (GAP_CLK + 10) @(negedge clk);
    chk("ignored_no_restart", mw_cs, 0);
    chk("ignored_ready_back", ready, 1);

    issue("rst_mid", 6'h2A, 1'b0);
    while (cyc < c0 + SK_DIV + 2 * SK_DIV * (CMD_W + 5) + 2) @(negedge clk);
    chk("rst_mid_rises", m_rises, CMD_W + 1 + 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs", mw_cs, 0);
    chk("rst_mid_sk", mw_sk, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rdata", rdata, 0);
    rst_n = 1'b1;
    if (q.size() != 0) tmp = q.pop_front();
    n_rv = 0;
    repeat (LAT + 50) begin
      @(negedge clk);
      if (rvalid === 1'b1) n_rv++;
    end
    chk("rst_mid_no_rvalid", n_rv, 0);

    issue("post_rst", 6'h11, 1'b0);
    wait_rsp("post_rst");

`ifdef MW93_DUMMY_CHECK_EN
    issue("err_set", 6'h07, 1'b1);
    wait_rsp("err_set");
    issue("err_clr", 6'h08, 1'b0);
    wait_rsp("err_clr");
`endif

    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
